// File: rtl/ld_current_monitor.sv
// Supervisor for the laser-diode driver current bus: strobes ramp steps, classifies
// the sampled current ramp and latches over-limit / step / stuck faults until cleared.
module ld_current_monitor #(
    parameter int TICK_DIV = 1000,
    parameter int I_MAX    = 2000,
    parameter int STEP_UP  = 2,
    parameter int STEP_DN  = 4,
    parameter int STUCK_N  = 4
) (
    input  logic        CLK,
    input  logic        Clrn,
    input  logic        LD_REQ,
    input  logic        FAULT_CLR,
    input  logic [11:0] I_in,
    output logic        C_out,
    output logic        LD_ON,
    output logic [2:0]  state,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [11:0] i_peak
);
    localparam int              CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int              SW        = $clog2(STUCK_N + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [11:0]     IMAX      = 12'(I_MAX);
    localparam logic [12:0]     D_UP      = 13'(STEP_UP);
    localparam logic [12:0]     D_DN      = 13'(-STEP_DN);
    localparam logic [SW-1:0]   STUCK_LIM = SW'(STUCK_N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_UP    = 3'b001,
        S_HOLD  = 3'b010,
        S_DOWN  = 3'b011,
        S_FAULT = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        F_NONE  = 2'b00,
        F_OVER  = 2'b01,
        F_STEP  = 2'b10,
        F_STUCK = 2'b11
    } code_t;

    logic [CW-1:0] cnt_q;
    logic          check_q;
    state_t        state_q, state_n;
    logic          fault_q, fault_n;
    code_t         code_q, code_n;
    logic [SW-1:0] stuck_q, stuck_n;
    logic [11:0]   i_prev_q, i_prev_n;
    logic [11:0]   i_peak_q, i_peak_n;
    logic          ld_on_q;

    logic [12:0] delta;
    logic        d_zero, d_up, d_dn, over, below, stuck_inc, clear_ok;

    // Driver latches the step on the edge that samples C_out, so the cycle after is the check.
    assign C_out     = (cnt_q == CNT_LAST);
    assign delta     = {1'b0, I_in} - {1'b0, i_prev_q};
    assign d_zero    = (delta == '0);
    assign d_up      = (delta == D_UP);
    assign d_dn      = (delta == D_DN);
    assign over      = (I_in > IMAX);
    assign below     = (I_in < IMAX);
    assign stuck_inc = (state_q == S_UP) && d_zero && below;
    assign clear_ok  = FAULT_CLR && (I_in == '0);

    always_comb begin
        state_n  = state_q;
        fault_n  = fault_q;
        code_n   = code_q;
        stuck_n  = stuck_q;
        i_prev_n = i_prev_q;
        i_peak_n = (I_in > i_peak_q) ? I_in : i_peak_q;
        if (state_q == S_FAULT) begin
            i_peak_n = i_peak_q;
            if (check_q) begin
                i_prev_n = I_in;
                stuck_n  = '0;
            end
            if (clear_ok) begin
                state_n  = S_IDLE;
                fault_n  = 1'b0;
                code_n   = F_NONE;
                stuck_n  = '0;
                i_prev_n = '0;
                i_peak_n = '0;
            end
        end else if (check_q) begin
            i_prev_n = I_in;
            if (stuck_inc)
                stuck_n = (stuck_q < STUCK_LIM) ? stuck_q + SW'(1) : stuck_q;
            else
                stuck_n = '0;
            if (over) begin
                state_n = S_FAULT;
                fault_n = 1'b1;
                code_n  = F_OVER;
            end else if (!(d_zero || d_up || d_dn)) begin
                state_n = S_FAULT;
                fault_n = 1'b1;
                code_n  = F_STEP;
            end else if (stuck_inc && (stuck_n == STUCK_LIM)) begin
                state_n = S_FAULT;
                fault_n = 1'b1;
                code_n  = F_STUCK;
            end else if (d_up) begin
                state_n = S_UP;
            end else if (d_dn) begin
                state_n = S_DOWN;
            end else if (I_in <= 12'd1) begin
                state_n = S_IDLE;
            end else if (!below) begin
                state_n = S_HOLD;
            end
        end
    end

    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            cnt_q    <= '0;
            check_q  <= 1'b0;
            state_q  <= S_IDLE;
            fault_q  <= 1'b0;
            code_q   <= F_NONE;
            stuck_q  <= '0;
            i_prev_q <= '0;
            i_peak_q <= '0;
            ld_on_q  <= 1'b0;
        end else begin
            cnt_q    <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            check_q  <= C_out;
            state_q  <= state_n;
            fault_q  <= fault_n;
            code_q   <= code_n;
            stuck_q  <= stuck_n;
            i_prev_q <= i_prev_n;
            i_peak_q <= i_peak_n;
            ld_on_q  <= LD_REQ & ~fault_n;
        end
    end

    assign LD_ON      = ld_on_q;
    assign state      = state_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign i_peak     = i_peak_q;

endmodule

// File: tb/tb_ld_current_monitor.sv
// Scoreboard bench for ld_current_monitor: a behavioural driver/supervisor model
// queues the expected flags per check; a monitor compares them two cycles after C_out.
module tb_ld_current_monitor;
    localparam int TICK_DIV = 8;
    localparam int I_MAX    = 2000;
    localparam int STEP_UP  = 2;
    localparam int STEP_DN  = 4;
    localparam int STUCK_N  = 4;

    localparam int S_IDLE = 0, S_UP = 1, S_HOLD = 2, S_DOWN = 3, S_FAULT = 4;

    logic        CLK = 1'b0;
    logic        Clrn = 1'b1;
    logic        LD_REQ = 1'b0;
    logic        FAULT_CLR = 1'b0;
    logic [11:0] I_in = '0;
    logic        C_out, LD_ON, fault;
    logic [2:0]  state;
    logic [1:0]  fault_code;
    logic [11:0] i_peak;

    ld_current_monitor #(
        .TICK_DIV(TICK_DIV),
        .I_MAX   (I_MAX),
        .STEP_UP (STEP_UP),
        .STEP_DN (STEP_DN),
        .STUCK_N (STUCK_N)
    ) dut (
        .CLK       (CLK),
        .Clrn      (Clrn),
        .LD_REQ    (LD_REQ),
        .FAULT_CLR (FAULT_CLR),
        .I_in      (I_in),
        .C_out     (C_out),
        .LD_ON     (LD_ON),
        .state     (state),
        .fault     (fault),
        .fault_code(fault_code),
        .i_peak    (i_peak)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int st;
        int flt;
        int code;
        int ld;
        int peak;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_state, m_fault, m_code, m_prev, m_run, m_peak;
    int cur;
    bit req;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_fault = 0; m_code = 0; m_prev = 0; m_run = 0; m_peak = 0;
    endtask

    task automatic model_fault(input int c);
        m_state = S_FAULT;
        m_fault = 1;
        m_code  = c;
    endtask

    task automatic model_check(input int v);
        int   d;
        exp_t e;
        if (m_state != S_FAULT && v > m_peak) m_peak = v;
        d = v - m_prev;
        m_prev = v;
        if (m_state == S_FAULT) begin
            m_run = 0;
        end else begin
            if (m_state == S_UP && d == 0 && v < I_MAX) m_run = m_run + 1;
            else m_run = 0;
            if (v > I_MAX) model_fault(1);
            else if (d != 0 && d != STEP_UP && d != -STEP_DN) model_fault(2);
            else if (m_run >= STUCK_N) model_fault(3);
            else if (d == STEP_UP) m_state = S_UP;
            else if (d == -STEP_DN) m_state = S_DOWN;
            else if (v <= 1) m_state = S_IDLE;
            else if (v >= I_MAX) m_state = S_HOLD;
        end
        e.st = m_state; e.flt = m_fault; e.code = m_code;
        e.ld = (req && m_fault == 0) ? 1 : 0;
        e.peak = m_peak;
        sbq.push_back(e);
    endtask

    // Returns at the negedge of the C_out cycle; n = negedges waited, -1 on timeout.
    task automatic wait_cout(output int n);
        n = 0;
        while (n < 3 * TICK_DIV) begin
            @(negedge CLK);
            n++;
            if (C_out) return;
        end
        n = -1;
    endtask

    // Drives the driver's settled value in the check cycle; returns 2 cycles later.
    task automatic apply_check(input int v);
        @(posedge CLK); #1;
        cur = v;
        I_in = 12'(v);
        LD_REQ = req;
        model_check(v);
        @(posedge CLK); @(posedge CLK); #1;
    endtask

    task automatic step(input int v);
        int n;
        wait_cout(n);
        check("cout_seen", int'(C_out), 1);
        apply_check(v);
    endtask

    task automatic clear_fault();
        I_in = '0;
        cur = 0;
        FAULT_CLR = 1'b1;
        @(posedge CLK); #1;
        FAULT_CLR = 1'b0;
        m_state = S_IDLE; m_fault = 0; m_code = 0; m_run = 0; m_peak = 0; m_prev = 0;
        check("clr_state", int'(state), m_state);
        check("clr_fault", int'(fault), m_fault);
        check("clr_code", int'(fault_code), m_code);
        check("clr_peak", int'(i_peak), m_peak);
    endtask

    task automatic glitch();
        int g;
        g = int'($urandom_range(0, 4095));
        I_in = 12'(g);
        if (m_state != S_FAULT && g > m_peak) m_peak = g;
        @(posedge CLK); #1;
        I_in = 12'(cur);
        check("glitch_peak", int'(i_peak), m_peak);
        check("glitch_state", int'(state), m_state);
    endtask

    task automatic check_reset_outputs();
        check("rst_cout", int'(C_out), 0);
        check("rst_ld_on", int'(LD_ON), 0);
        check("rst_state", int'(state), S_IDLE);
        check("rst_fault", int'(fault), 0);
        check("rst_code", int'(fault_code), 0);
        check("rst_peak", int'(i_peak), 0);
    endtask

    // Monitor: one expected record per check, compared once flags have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (Clrn && C_out) begin
                @(negedge CLK);
                @(negedge CLK);
                check("sb_nonempty", int'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("sb_state", int'(state), e.st);
                    check("sb_fault", int'(fault), e.flt);
                    check("sb_code", int'(fault_code), e.code);
                    check("sb_ld_on", int'(LD_ON), e.ld);
                    check("sb_peak", int'(i_peak), e.peak);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v, n, h;
        req = 1'b1;
        LD_REQ = 1'b1;
        model_reset();
        cur = 0;

        // Power-on reset, checked before any clock edge
        #2 Clrn = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(posedge CLK);
        #1 Clrn = 1'b1;
        wait_cout(n);
        check("first_cout", n, TICK_DIV);
        apply_check(0);

        // Ramp up to the ceiling with occasional short plateaus
        v = 0;
        while (v < I_MAX) begin
            v += STEP_UP;
            step(v);
            if (v < I_MAX && $urandom_range(0, 5) == 0) begin
                h = int'($urandom_range(1, STUCK_N - 1));
                repeat (h) step(v);
            end
        end
        step(I_MAX);
        step(I_MAX);

        // Drop request in HOLD, then ramp down to zero
        check("hold_ld_on", int'(LD_ON), 1);
        req = 1'b0;
        LD_REQ = 1'b0;
        check("ld_same_cycle", int'(LD_ON), 1);
        @(posedge CLK); #1;
        check("ld_latency", int'(LD_ON), 0);
        v = I_MAX;
        while (v > 0) begin
            v -= STEP_DN;
            step(v);
        end
        step(0);

        // Illegal step, then a later illegal value must not overwrite the code
        req = 1'b1;
        step(2); step(4); step(6); step(6); step(2); step(1);
        step(4094);
        clear_fault();
        step(0);

        // Stuck ramp, then clear attempts
        v = 0;
        while (v < 100) begin
            v += STEP_UP;
            step(v);
        end
        repeat (STUCK_N) step(100);
        FAULT_CLR = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        FAULT_CLR = 1'b0;
        check("clr_nonzero_state", int'(state), S_FAULT);
        check("clr_nonzero_fault", int'(fault), 1);
        step(100);
        I_in = '0;
        cur = 0;
        @(posedge CLK); #1;
        check("zero_no_clr_state", int'(state), S_FAULT);
        clear_fault();
        step(0);

        // Over-limit from idle, peak frozen through later checks and glitches
        step(2002);
        step(3000);
        glitch();
        clear_fault();
        step(0);

        // Asynchronous reset mid-ramp
        v = 0;
        while (v < 500) begin
            v += STEP_UP;
            step(v);
        end
        Clrn = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge CLK);
        #1;
        I_in = '0;
        cur = 0;
        Clrn = 1'b1;
        model_reset();
        sbq.delete();
        wait_cout(n);
        check("first_cout_after_rst", n, TICK_DIV);
        apply_check(0);

        // Randomized ramp activity
        for (int k = 0; k < 300; k++) begin
            int r, nv;
            r = int'($urandom_range(0, 9));
            if (r <= 3) nv = cur + STEP_UP;
            else if (r <= 5) nv = cur - STEP_DN;
            else if (r <= 7) nv = cur;
            else nv = int'($urandom_range(0, 4095));
            if (nv > 4095 || nv < 0) nv = cur;
            if ($urandom_range(0, 7) == 0) req = !req;
            step(nv);
            if (m_fault != 0 && $urandom_range(0, 1) == 1) clear_fault();
            else if ($urandom_range(0, 7) == 0) glitch();
        end

        check("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
